// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit sequential ALU front end.
// Holds the 3-bit operation codes understood by the external 4-bit ALU,
// the FSM state encoding of alu8_seq, and a helper that tells which
// operations alu8_seq can build out of two nibble passes.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LO_ISS  = 3'd1,
        ST_LO_CAP  = 3'd2,
        ST_HI_ISS  = 3'd3,
        ST_HI_CAP  = 3'd4,
        ST_INC_ISS = 3'd5,
        ST_INC_CAP = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    // SUB and LT need borrow/compare chaining across nibbles, which this
    // front end does not implement, so they are rejected as illegal.
    function automatic logic is_legal(input logic [2:0] op);
        return !((op == OP_SUB) || (op == OP_LT));
    endfunction

endpackage

// File: rtl/alu8_seq_if.sv
// Request/response bus of alu8_seq.
// Handshake rule for both channels: a transfer happens on the rising clock
// edge where valid and ready are both 1; the producer holds valid and its
// payload stable until that edge.
//   req_*: master -> slave operation request (op, a, b), req_ready back.
//   rsp_*: slave -> master result and flags, rsp_ready back.
interface alu8_seq_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_ovf;
    logic       rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_err
    );
endinterface

// File: rtl/alu8_seq.sv
// 8-bit ALU built by sequencing an external clocked 4-bit ALU.
// A request is split into a low-nibble pass and a high-nibble pass; an ADD
// whose low pass carries out gets a third pass that increments the high sum.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   bus (slave)       request/response handshake bus
//   alu_choose/a/b    registered drive to the 4-bit ALU
//   alu_out/cin/m     4-bit ALU result, carry-out, equal flag (one cycle later)
//   fsm_state         current FSM state for observation
module alu8_seq
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    alu8_seq_if.slave  bus,
    output logic [2:0] alu_choose,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic       alu_cin,
    input  logic       alu_m,
    input  logic [3:0] alu_out,
    output state_t     fsm_state
);

    state_t     state, next_state;
    logic [2:0] op_q;
    logic [3:0] a_hi_q, b_hi_q, lo_q;
    logic       c0_q, c1_q, e_lo_q;
    logic [7:0] result_q;
    logic       carry_q, ovf_q, err_q;
    logic [7:0] fin_result;
    logic       fin_carry, fin_ovf;
    logic       accept, finish;

    assign accept         = (state == ST_IDLE) && bus.req_valid;
    assign finish         = ((state == ST_HI_CAP) || (state == ST_INC_CAP)) && (next_state == ST_DONE);
    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.rsp_valid  = (state == ST_DONE);
    assign bus.rsp_result = result_q;
    assign bus.rsp_carry  = carry_q;
    assign bus.rsp_ovf    = ovf_q;
    assign bus.rsp_err    = err_q;
    assign fsm_state      = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (bus.req_valid) next_state = is_legal(bus.req_op) ? ST_LO_ISS : ST_DONE;
            ST_LO_ISS:  next_state = ST_LO_CAP;
            ST_LO_CAP:  next_state = ST_HI_ISS;
            ST_HI_ISS:  next_state = ST_HI_CAP;
            ST_HI_CAP:  next_state = ((op_q == OP_ADD) && c0_q) ? ST_INC_ISS : ST_DONE;
            ST_INC_ISS: next_state = ST_INC_CAP;
            ST_INC_CAP: next_state = ST_DONE;
            ST_DONE:    if (bus.rsp_ready) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Final response built from the last capture cycle. The high nibble is
    // always alu_out; in INC_CAP the high-pass carry comes from c1_q because
    // alu_cin then reflects the increment.
    always_comb begin
        fin_result = {alu_out, lo_q};
        fin_carry  = 1'b0;
        fin_ovf    = 1'b0;
        if (op_q == OP_EQ) fin_result = {7'b0, e_lo_q & alu_m};
        if (op_q == OP_ADD) begin
            fin_carry = (state == ST_INC_CAP) ? (c1_q | alu_cin) : alu_cin;
            fin_ovf   = (a_hi_q[3] == b_hi_q[3]) && (alu_out[3] != a_hi_q[3]);
        end
    end

    // ALU drive registers load on the edge entering an *_ISS state, so they
    // are stable for the whole issue cycle and hold everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= 3'b000;
            a_hi_q     <= 4'h0;
            b_hi_q     <= 4'h0;
            lo_q       <= 4'h0;
            c0_q       <= 1'b0;
            c1_q       <= 1'b0;
            e_lo_q     <= 1'b0;
            alu_choose <= 3'b000;
            alu_a      <= 4'h0;
            alu_b      <= 4'h0;
            result_q   <= 8'h00;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q   <= bus.req_op;
                        a_hi_q <= bus.req_a[7:4];
                        b_hi_q <= bus.req_b[7:4];
                        if (is_legal(bus.req_op)) begin
                            alu_choose <= bus.req_op;
                            alu_a      <= bus.req_a[3:0];
                            alu_b      <= bus.req_b[3:0];
                        end else begin
                            result_q <= 8'h00;
                            carry_q  <= 1'b0;
                            ovf_q    <= 1'b0;
                            err_q    <= 1'b1;
                        end
                    end
                end
                ST_LO_CAP: begin
                    lo_q   <= alu_out;
                    c0_q   <= alu_cin;
                    e_lo_q <= alu_m;
                    alu_a  <= a_hi_q;
                    alu_b  <= b_hi_q;
                end
                ST_HI_CAP: begin
                    c1_q <= alu_cin;
                    if (next_state == ST_INC_ISS) begin
                        alu_choose <= OP_ADD;
                        alu_a      <= alu_out;
                        alu_b      <= 4'b0001;
                    end
                end
                default: ;
            endcase
            if (finish) begin
                result_q <= fin_result;
                carry_q  <= fin_carry;
                ovf_q    <= fin_ovf;
                err_q    <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu8_seq.md
ALU8_SEQ -- requirements
Module: alu8_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; clock and reset are listed first below.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  block can accept a request.
REQ-006 req_op  in  3  operation: 000 ADD, 010 NOT, 011 AND, 100 OR, 101 XOR, 111 EQ; 001 and 110 illegal.
REQ-007 req_a, req_b  in  8  operands; req_b ignored for NOT.
REQ-008 rsp_valid  out  1  response present.
REQ-009 rsp_ready  in  1  consumer accepts response.
REQ-010 rsp_result  out  8  8-bit result.
REQ-011 rsp_carry, rsp_ovf, rsp_err  out  1 each  carry-out, signed overflow, illegal-op flag.
REQ-012 alu_choose  out  3;  alu_a, alu_b  out  4 each  registered drive to the 4-bit clocked ALU.
REQ-013 alu_cin, alu_m  in  1 each;  alu_out  in  4  ALU results, valid the cycle after the ALU samples its inputs.

Function
REQ-014 Request accepted on the rising edge where req_valid and req_ready are both 1; req_ready SHALL be 1 only in IDLE.
REQ-015 Operands and op SHALL be latched at acceptance; later req_* changes have no effect.
REQ-016 FSM states: IDLE, LO_ISS, LO_CAP, HI_ISS, HI_CAP, INC_ISS, INC_CAP, DONE.
REQ-017 *_ISS: alu_choose/alu_a/alu_b driven with pass op and nibbles; *_CAP: alu_out/alu_cin sampled at end of cycle. Each pass therefore takes 2 cycles.
REQ-018 Legal op: IDLE -> LO_ISS (low nibbles) -> LO_CAP -> HI_ISS (high nibbles) -> HI_CAP -> DONE.
REQ-019 ADD with low-pass carry c0=1: HI_CAP -> INC_ISS (choose 000, a=high sum, b=0001) -> INC_CAP -> DONE.
REQ-020 ADD: rsp_carry = c1 | c2 (c2=0 if INC skipped); rsp_ovf = (a[7]==b[7]) & (result[7]!=a[7]), computed locally.
REQ-021 NOT/AND/OR/XOR: result = {hi, lo} nibble results; rsp_carry = rsp_ovf = 0.
REQ-022 EQ: rsp_result = {7'b0, e_lo & e_hi}; carry/ovf 0.
REQ-023 Illegal op: IDLE -> DONE directly, rsp_err=1, result/carry/ovf 0, no ALU pass.
REQ-024 Latency from accept edge (cycle 0): rsp_valid=1 in cycle 5 (no INC), cycle 7 (INC), cycle 1 (illegal).
REQ-025 DONE: rsp_* held stable while rsp_valid=1 and rsp_ready=0; transition to IDLE on edge with rsp_ready=1.
REQ-026 No request accepted in the cycle the response is consumed (IDLE reached next cycle).
REQ-027 Outside *_ISS states alu_choose/alu_a/alu_b SHALL hold their last value.

Reset
REQ-028 rst SHALL force IDLE immediately, regardless of clk, aborting any op in flight with no response.
REQ-029 Reset values: req_ready 1 (once rst deasserted), rsp_valid 0, rsp_result 0, rsp_carry/ovf/err 0, alu_choose 000, alu_a/alu_b 0.

Structure
REQ-030 Shared package alu_pkg SHALL hold op-code constants (ADD, SUB, NOT, AND, OR, XOR, LT, EQ) and the FSM state encoding.
REQ-031 No sub-module; the 4-bit ALU is instantiated beside alu8_seq in the bench/top, not inside it.

Verification
REQ-032 ADD 0x3A+0x4F -> result 0x89, carry 0, ovf 1, INC pass taken, rsp_valid at cycle 7.
REQ-033 ADD 0xFF+0x01 -> result 0x00, carry 1, ovf 0; ADD 0x0F+0xF0 -> 0xFF, carry 0, rsp_valid at cycle 5.
REQ-034 XOR 0xA5^0x3C -> 0x99; NOT 0x5A -> 0xA5; EQ 0x5A,0x5A -> 0x01; EQ 0x5A,0x5B -> 0x00.
REQ-035 op 001 -> rsp_err 1, result 0x00, rsp_valid at cycle 1, ALU drive unchanged.
REQ-036 rsp_ready held 0 for 3 cycles after rsp_valid -> outputs stable, req_ready 0; rsp_ready 1 -> IDLE next cycle.
REQ-037 rst asserted mid-HI_CAP -> rsp_valid 0 and all outputs at reset values without a clk edge; next request completes correctly.
